// File: rtl/param_regfile_pkg.sv
// Shared types and default parameters for the parameterised register file
// and its clear sequencer.
package param_regfile_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_ADDR_W   = 3;
    localparam int unsigned DEF_NUM_RD   = 2;
    localparam int unsigned DEF_ZERO_REG = 0;
    localparam int unsigned DEF_BYPASS   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks a counter over every register address, one per cycle,
// then pulses done for a single cycle before returning to idle.
module regfile_clr_fsm
    import param_regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
    output logic              done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] cnt
);

    localparam int unsigned       DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    clr_state_e        state;
    clr_state_e        state_next;
    logic [ADDR_W-1:0] cnt_next;

    // busy/done are registered copies of the next state so they track state exactly
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= (state_next == CLEAR);
            done  <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt + ADDR_W'(1);
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign clr_we = busy;

endmodule

// File: rtl/param_regfile.sv
// Multi-read, dual-write register file with optional write-to-read bypass,
// optional hardwired-zero register 0 and a sequenced whole-array clear.
module param_regfile
    import param_regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter int unsigned ZERO_REG = DEF_ZERO_REG,
    parameter int unsigned BYPASS   = DEF_BYPASS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en0,
    input  logic                     wr_en1,
    input  logic [ADDR_W-1:0]        wr_addr0,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic [DATA_W-1:0]        wr_data0,
    input  logic [DATA_W-1:0]        wr_data1,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rf [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_cnt;
    logic              idle;
    logic              wr_ok0;
    logic              wr_ok1;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clock   (clock),
        .reset   (reset),
        .clr_req (clr_req),
        .busy    (clr_busy),
        .done    (clr_done),
        .clr_we  (clr_we),
        .cnt     (clr_cnt)
    );

    assign idle   = !clr_busy && !clr_done;
    assign wr_ok0 = wr_en0 && idle && !((ZERO_REG != 0) && (wr_addr0 == '0));
    assign wr_ok1 = wr_en1 && idle && !((ZERO_REG != 0) && (wr_addr1 == '0));

    // Port 1 is written last so it wins an address collision
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                rf[i] <= '0;
            end
        end else if (clr_we) begin
            rf[clr_cnt] <= '0;
        end else begin
            if (wr_ok0) rf[wr_addr0] <= wr_data0;
            if (wr_ok1) rf[wr_addr1] <= wr_data1;
        end
    end

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        // wr_ok already excludes clear states and the hardwired-zero register
        always_comb begin
            val = rf[ra];
            if ((BYPASS != 0) && wr_ok0 && (wr_addr0 == ra)) val = wr_data0;
            if ((BYPASS != 0) && wr_ok1 && (wr_addr1 == ra)) val = wr_data1;
            if ((ZERO_REG != 0) && (ra == '0)) val = '0;
            if (reset) val = '0;
        end

        assign rd_data[k*DATA_W +: DATA_W] = val;
    end

endmodule

// File: tb/tb_param_regfile.sv
// Bench for param_regfile: default instance plus a ZERO_REG=1 instance, with
// expected read data queued at stimulus time and popped when sampled.
module tb_param_regfile;

    logic        clock;
    logic        reset;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en0, wr_en1;
    logic [2:0]  wr_addr0, wr_addr1;
    logic [15:0] wr_data0, wr_data1;
    logic        clr_req, clr_busy, clr_done;

    logic [5:0]  z_rd_addr;
    logic [31:0] z_rd_data;
    logic        z_wr_en0, z_wr_en1;
    logic [2:0]  z_wr_addr0, z_wr_addr1;
    logic [15:0] z_wr_data0, z_wr_data1;
    logic        z_clr_req, z_clr_busy, z_clr_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    param_regfile dut (
        .clock    (clock),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en0   (wr_en0),
        .wr_en1   (wr_en1),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    param_regfile #(.ZERO_REG(1)) dut_z (
        .clock    (clock),
        .reset    (reset),
        .rd_addr  (z_rd_addr),
        .rd_data  (z_rd_data),
        .wr_en0   (z_wr_en0),
        .wr_en1   (z_wr_en1),
        .wr_addr0 (z_wr_addr0),
        .wr_addr1 (z_wr_addr1),
        .wr_data0 (z_wr_data0),
        .wr_data1 (z_wr_data1),
        .clr_req  (z_clr_req),
        .clr_busy (z_clr_busy),
        .clr_done (z_clr_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_all(input logic [15:0] v);
        for (int i = 0; i < 8; i += 2) begin
            @(negedge clock);
            wr_en0 = 1'b1; wr_addr0 = 3'(i);     wr_data0 = v;
            wr_en1 = 1'b1; wr_addr1 = 3'(i + 1); wr_data1 = v;
        end
        @(negedge clock);
        wr_en0 = 1'b0; wr_en1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_en0 = 1'b1; wr_addr0 = 3'd3; wr_data0 = 16'h9999;
        rd_addr = {3'd0, 3'd3};
        exp_q.push_back(32'h0);
        @(negedge clock);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL reset_rd_data: got %h expected %h", rd_data, exp_v);
        end
        n_checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", clr_busy, clr_done);
        end
        wr_en0 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (rd_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_no_write: got %h expected %h", rd_data, 32'h0);
        end
    endtask

    task automatic test_dual_write();
        @(negedge clock);
        wr_en0 = 1'b1; wr_addr0 = 3'd3; wr_data0 = 16'h1234;
        wr_en1 = 1'b1; wr_addr1 = 3'd5; wr_data1 = 16'hBEEF;
        rd_addr = {3'd5, 3'd3};
        exp_q.push_back({16'hBEEF, 16'h1234});
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL dual_bypass: got %h expected %h", rd_data, exp_v);
        end
        @(negedge clock);
        wr_en0 = 1'b0; wr_en1 = 1'b0;
        exp_q.push_back({16'hBEEF, 16'h1234});
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL dual_read: got %h expected %h", rd_data, exp_v);
        end
    endtask

    task automatic test_collision();
        @(negedge clock);
        wr_en0 = 1'b1; wr_addr0 = 3'd2; wr_data0 = 16'h1111;
        wr_en1 = 1'b1; wr_addr1 = 3'd2; wr_data1 = 16'h2222;
        rd_addr = {3'd2, 3'd2};
        exp_q.push_back({16'h2222, 16'h2222});
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL collision_bypass: got %h expected %h", rd_data, exp_v);
        end
        @(negedge clock);
        wr_en1 = 1'b0;
        wr_addr0 = 3'd4; wr_data0 = 16'h4444;
        rd_addr = {3'd2, 3'd4};
        exp_q.push_back({16'h2222, 16'h4444});
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL collision_hold_and_port0_bypass: got %h expected %h", rd_data, exp_v);
        end
        @(negedge clock);
        wr_en0 = 1'b0;
        rd_addr = {3'd3, 3'd4};
        exp_q.push_back({16'h1234, 16'h4444});
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL port0_commit: got %h expected %h", rd_data, exp_v);
        end
    endtask

    task automatic test_clear();
        fill_all(16'hFFFF);
        clr_req = 1'b1;
        @(negedge clock);
        clr_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            // third CLEAR cycle: try writing r7 (not yet cleared) and r0 (already cleared)
            wr_en0 = (i == 2); wr_addr0 = 3'd7; wr_data0 = 16'hAAAA;
            wr_en1 = (i == 2); wr_addr1 = 3'd0; wr_data1 = 16'h5A5A;
            rd_addr = {3'd7, 3'((i == 0) ? 0 : i - 1)};
            exp_q.push_back({16'hFFFF, (i == 0) ? 16'hFFFF : 16'h0000});
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (rd_data !== exp_v) begin
                n_fail++; $display("FAIL clear_read_cycle%0d: got %h expected %h", i, rd_data, exp_v);
            end
            n_checks++;
            if (clr_busy !== 1'b1 || clr_done !== 1'b0) begin
                n_fail++; $display("FAIL clear_busy_cycle%0d: got busy=%b done=%b expected 1 0", i, clr_busy, clr_done);
            end
            @(negedge clock);
        end
        wr_en0 = 1'b0; wr_en1 = 1'b0;
        n_checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b1) begin
            n_fail++; $display("FAIL clear_done_pulse: got busy=%b done=%b expected 0 1", clr_busy, clr_done);
        end
        @(negedge clock);
        n_checks++;
        if (clr_done !== 1'b0) begin
            n_fail++; $display("FAIL clear_done_width: got %b expected 0", clr_done);
        end
        for (int i = 0; i < 8; i += 2) begin
            rd_addr = {3'(i + 1), 3'(i)};
            exp_q.push_back(32'h0);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (rd_data !== exp_v) begin
                n_fail++; $display("FAIL clear_result_r%0d: got %h expected %h", i, rd_data, exp_v);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_clear_with_write();
        int cyc;
        clr_req = 1'b1;
        wr_en1 = 1'b1; wr_addr1 = 3'd6; wr_data1 = 16'h6666;
        @(negedge clock);
        clr_req = 1'b0; wr_en1 = 1'b0;
        rd_addr = {3'd6, 3'd0};
        exp_q.push_back({16'h6666, 16'h0000});
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL req_cycle_write_committed: got %h expected %h", rd_data, exp_v);
        end
        cyc = 0;
        while (clr_done !== 1'b1 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        n_checks++;
        if (cyc != 8) begin
            n_fail++; $display("FAIL req_cycle_done_latency: got %0d cycles expected 8", cyc);
        end
        @(negedge clock);
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL req_cycle_write_overwritten: got %h expected %h", rd_data, exp_v);
        end
    endtask

    task automatic test_reset_mid_clear();
        int done_seen;
        fill_all(16'h3C3C);
        clr_req = 1'b1;
        @(negedge clock);
        clr_req = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        rd_addr = {3'd7, 3'd6};
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (clr_busy !== 1'b0) begin
            n_fail++; $display("FAIL midclear_busy: got %b expected 0", clr_busy);
        end
        n_checks++;
        if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL midclear_rd_data: got %h expected %h", rd_data, exp_v);
        end
        @(negedge clock);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (clr_done === 1'b1 || clr_busy === 1'b1) done_seen++;
            @(negedge clock);
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++; $display("FAIL midclear_no_done: got %0d active cycles expected 0", done_seen);
        end
        for (int i = 0; i < 8; i += 2) begin
            rd_addr = {3'(i + 1), 3'(i)};
            exp_q.push_back(32'h0);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (rd_data !== exp_v) begin
                n_fail++; $display("FAIL midclear_regs_r%0d: got %h expected %h", i, rd_data, exp_v);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clock);
        z_wr_en0 = 1'b1; z_wr_addr0 = 3'd0; z_wr_data0 = 16'h5555;
        z_wr_en1 = 1'b1; z_wr_addr1 = 3'd1; z_wr_data1 = 16'h7777;
        z_rd_addr = {3'd1, 3'd0};
        exp_q.push_back({16'h7777, 16'h0000});
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (z_rd_data !== exp_v) begin
            n_fail++; $display("FAIL zero_reg_same_cycle: got %h expected %h", z_rd_data, exp_v);
        end
        @(negedge clock);
        z_wr_en0 = 1'b0; z_wr_en1 = 1'b0;
        exp_q.push_back({16'h7777, 16'h0000});
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (z_rd_data !== exp_v) begin
            n_fail++; $display("FAIL zero_reg_after: got %h expected %h", z_rd_data, exp_v);
        end
    endtask

    initial begin
        reset = 1'b1;
        rd_addr = '0; wr_en0 = 1'b0; wr_en1 = 1'b0;
        wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0; clr_req = 1'b0;
        z_rd_addr = '0; z_wr_en0 = 1'b0; z_wr_en1 = 1'b0;
        z_wr_addr0 = '0; z_wr_addr1 = '0; z_wr_data0 = '0; z_wr_data1 = '0; z_clr_req = 1'b0;

        test_reset();
        test_dual_write();
        test_collision();
        test_clear();
        test_clear_with_write();
        test_reset_mid_clear();
        test_zero_reg();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_regfile.md
PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 0; when 1, register 0 is hardwired to zero.
REQ-005 SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to matching read ports.
REQ-006 SHALL have port: clock  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port: rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port: rd_data  output  NUM_RD*DATA_W  packed read data, port k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have ports: wr_en0, wr_en1  input  1  write enables, ports 0 and 1.
REQ-011 SHALL have ports: wr_addr0, wr_addr1  input  ADDR_W  write addresses.
REQ-012 SHALL have ports: wr_data0, wr_data1  input  DATA_W  write data.
REQ-013 SHALL have port: clr_req  input  1  request to zero the whole array.
REQ-014 SHALL have port: clr_busy  output  1  clear sequence in progress.
REQ-015 SHALL have port: clr_done  output  1  one-cycle pulse at clear completion.

Function
REQ-016 SHALL provide combinational (zero-latency) reads: rd_data[k] = RF[rd_addr[k]].
REQ-017 SHALL commit writes on the rising edge when wr_enN=1 and the clear FSM is in IDLE.
REQ-018 SHALL resolve two writes to the same address in one cycle by having port 1 win.
REQ-019 SHALL, with BYPASS=1 in IDLE, return wr_data of the enabled matching write port on rd_data[k] in that cycle, port 1 taking priority over port 0.
REQ-020 SHALL, with ZERO_REG=1, read register 0 as zero, never bypass to it, and ignore writes to it.
REQ-021 SHALL implement FSM states IDLE, CLEAR, DONE.
REQ-022 SHALL transition IDLE->CLEAR on clr_req=1 at a rising edge, loading clear counter to 0.
REQ-023 SHALL, in CLEAR, zero RF[cnt] each cycle and increment cnt; after cnt=DEPTH-1 it transitions to DONE.
REQ-024 SHALL remain in CLEAR for exactly DEPTH cycles, with clr_busy=1 only in CLEAR.
REQ-025 SHALL hold DONE for one cycle with clr_done=1, then return to IDLE unconditionally.
REQ-026 SHALL drop writes on both write ports, and disable bypass, while in CLEAR or DONE.
REQ-027 SHALL ignore clr_req while in CLEAR or DONE; a clr_req held high in IDLE after DONE starts a new sequence.
REQ-028 SHALL, during CLEAR, return current array contents on reads: already-cleared entries read zero, the rest read old values.
REQ-029 SHALL commit a write presented in the same IDLE cycle as clr_req, after which the clear sequence overwrites it.

Reset
REQ-030 SHALL, on reset=1, asynchronously set all registers to zero, FSM to IDLE, and counter to zero.
REQ-031 SHALL drive clr_busy=0, clr_done=0, and rd_data=0 during reset.
REQ-032 SHALL abort an in-progress clear on reset, with no clr_done pulse.

Structure
REQ-033 SHALL take the FSM state typedef (IDLE/CLEAR/DONE) and default parameter constants from shared package param_regfile_pkg.
REQ-034 SHALL place the clear sequencer (FSM plus counter, outputs busy/done/cnt/clr_we) in sub-module regfile_clr_fsm.

Verification
REQ-035 SHALL verify dual-port write/read: with defaults, write 0x1234 to r3 and 0xBEEF to r5 in one cycle -> next cycle rd_addr={5,3} gives rd_data={0xBEEF,0x1234}.
REQ-036 SHALL verify write collision and bypass: wr0 r2=0x1111 and wr1 r2=0x2222 with rd_addr0=2 -> same-cycle rd_data0=0x2222, and r2 holds 0x2222 afterwards.
REQ-037 SHALL verify the clear sequence: fill r0..r7=0xFFFF, pulse clr_req -> clr_busy high 8 cycles, clr_done high on the 9th, then all eight reads return 0.
REQ-038 SHALL verify writes blocked during clear: issue wr0 r7=0xAAAA in the 3rd CLEAR cycle -> r7 reads 0 after clr_done.
REQ-039 SHALL verify reset mid-clear: assert reset in the 4th CLEAR cycle -> clr_busy=0 immediately, no clr_done, all registers 0.
REQ-040 SHALL verify ZERO_REG=1: write 0x5555 to r0 -> r0 reads 0 both in the same cycle and afterwards.
